// File: rtl/tile_operand_packer.sv
// Packs a 32-bit operand word stream into paired 256-bit row/column beats.
// Optional stall counter: define TILE_PACKER_STALL_CNT_EN.
module tile_operand_packer (
  input  logic         clock_sink,
  input  logic         reset_sink_reset,
  input  logic [31:0]  st_cmd_data,
  input  logic         st_cmd_valid,
  output logic         st_cmd_ready,
  input  logic [31:0]  st_words_data,
  input  logic         st_words_valid,
  output logic         st_words_ready,
  output logic [31:0]  st_instr_data,
  output logic         st_instr_valid,
  input  logic         st_instr_ready,
  output logic [255:0] st_rows_data,
  output logic         st_rows_valid,
  input  logic         st_rows_ready,
  output logic [255:0] st_cols_data,
  output logic         st_cols_valid,
  input  logic         st_cols_ready,
  output logic         busy,
  output logic         cmd_err,
  output logic [31:0]  stall_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_PACK,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [9:0]   r_cmd;
  logic [4:0]   r_m;
  logic [8:0]   r_word_cnt;
  logic [4:0]   r_beat_cnt;
  logic         r_cmd_err;

  logic [511:0] r_pack_data;
  logic [3:0]   r_pack_idx;
  logic         r_pack_full;

  logic [255:0] r_out_rows;
  logic [255:0] r_out_cols;
  logic         r_out_valid;

  logic [4:0]   w_cmd_cols;
  logic [4:0]   w_cmd_rows;
  logic [4:0]   w_cmd_m;
  logic [8:0]   w_total;
  logic         w_cmd_fire;
  logic         w_instr_fire;
  logic         w_word_fire;
  logic         w_pair_ready;
  logic         w_out_fire;
  logic         w_out_free;
  logic         w_beat_done;
  logic         w_load_direct;
  logic         w_load_pack;
  logic         w_last_word;
  logic         w_last_beat;
  logic [511:0] w_done_beat;
  logic         w_unused;

  assign w_unused   = ^st_cmd_data[31:10];

  assign w_cmd_cols = st_cmd_data[4:0];
  assign w_cmd_rows = st_cmd_data[9:5];
  assign w_cmd_m    = (w_cmd_cols < w_cmd_rows) ? w_cmd_cols : w_cmd_rows;
  assign w_total    = {r_m, 4'b0000};

  assign st_cmd_ready   = (r_state == S_IDLE);
  assign st_instr_valid = (r_state == S_ISSUE);
  assign st_instr_data  = {22'd0, r_cmd};
  assign st_words_ready = (r_state == S_PACK) && !r_pack_full
                        && (r_word_cnt < w_total);

  assign w_cmd_fire   = st_cmd_valid && st_cmd_ready;
  assign w_instr_fire = st_instr_valid && st_instr_ready;
  assign w_word_fire  = st_words_valid && st_words_ready;
  assign w_pair_ready = st_rows_ready && st_cols_ready;
  assign w_out_fire   = r_out_valid && w_pair_ready;
  assign w_out_free   = !r_out_valid || w_out_fire;

  // A completed beat skips the pack buffer when the output slot is available.
  assign w_beat_done   = w_word_fire && (r_pack_idx == 4'd15);
  assign w_load_direct = w_beat_done && w_out_free;
  assign w_load_pack   = r_pack_full && w_out_free;
  assign w_done_beat   = {st_words_data, r_pack_data[479:0]};

  assign w_last_word = (r_word_cnt == (w_total - 9'd1));
  assign w_last_beat = (r_beat_cnt == (r_m - 5'd1));

  assign st_rows_data  = r_out_rows;
  assign st_cols_data  = r_out_cols;
  assign st_rows_valid = r_out_valid;
  assign st_cols_valid = r_out_valid;
  assign busy          = (r_state != S_IDLE);
  assign cmd_err       = r_cmd_err;

  always_ff @(posedge clock_sink) begin
    if (reset_sink_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_cmd_fire && (w_cmd_m != 5'd0)) begin
          w_state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_instr_fire) begin
          w_state_nx = S_PACK;
        end
      end
      S_PACK: begin
        if (w_word_fire && w_last_word) begin
          w_state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_out_fire && w_last_beat) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_sink) begin
    if (reset_sink_reset) begin
      r_cmd      <= 10'd0;
      r_m        <= 5'd0;
      r_word_cnt <= 9'd0;
      r_beat_cnt <= 5'd0;
      r_cmd_err  <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        r_cmd      <= st_cmd_data[9:0];
        r_m        <= w_cmd_m;
        r_word_cnt <= 9'd0;
        r_beat_cnt <= 5'd0;
        if (w_cmd_m == 5'd0) begin
          r_cmd_err <= 1'b1;
        end
      end else begin
        if (w_word_fire) begin
          r_word_cnt <= r_word_cnt + 9'd1;
        end
        if (w_out_fire) begin
          r_beat_cnt <= r_beat_cnt + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clock_sink) begin
    if (reset_sink_reset) begin
      r_pack_data <= 512'd0;
      r_pack_idx  <= 4'd0;
      r_pack_full <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        r_pack_idx <= 4'd0;
      end else if (w_word_fire) begin
        r_pack_data[{r_pack_idx, 5'b00000} +: 32] <= st_words_data;
        r_pack_idx <= r_pack_idx + 4'd1;
      end
      if (w_beat_done && !w_out_free) begin
        r_pack_full <= 1'b1;
      end else if (w_load_pack) begin
        r_pack_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock_sink) begin
    if (reset_sink_reset) begin
      r_out_rows  <= 256'd0;
      r_out_cols  <= 256'd0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_load_direct) begin
        r_out_rows  <= w_done_beat[255:0];
        r_out_cols  <= w_done_beat[511:256];
        r_out_valid <= 1'b1;
      end else if (w_load_pack) begin
        r_out_rows  <= r_pack_data[255:0];
        r_out_cols  <= r_pack_data[511:256];
        r_out_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef TILE_PACKER_STALL_CNT_EN
  logic [31:0] r_stall;

  always_ff @(posedge clock_sink) begin
    if (reset_sink_reset) begin
      r_stall <= 32'd0;
    end else if (r_out_valid && !w_pair_ready
                 && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stall_count = r_stall;
`else
  assign stall_count = 32'd0;
`endif

endmodule
